// File: rtl/special_request_conditioner_if.sv
// Sensor/light inputs and request/status outputs between the
// emergency-sensor front-end and traffic_light.
interface special_request_conditioner_if;
  logic       Main_Sensor;
  logic       Side_Sensor;
  logic [2:0] Main_light;
  logic [2:0] Side_light;
  logic       Main_Special;
  logic       Side_Special;
  logic       Main_Pending;
  logic       Side_Pending;
  logic       Timeout_Pulse;

  modport master (
    output Main_Sensor, Side_Sensor, Main_light, Side_light,
    input  Main_Special, Side_Special, Main_Pending, Side_Pending, Timeout_Pulse
  );

  modport slave (
    input  Main_Sensor, Side_Sensor, Main_light, Side_light,
    output Main_Special, Side_Special, Main_Pending, Side_Pending, Timeout_Pulse
  );
endinterface

// File: rtl/special_request_conditioner.sv
// Emergency-vehicle request front-end: per-road sync/debounce lanes feeding a
// single-grant arbiter with green-or-timeout release and a fixed cooldown.

module src_lane #(
  parameter int DEBOUNCE = 4,
  parameter int CNT_W    = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sensor_i,
  output logic rise_o
);
  logic             s1_q, s2_q, filt_q, fprev_q, filt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;

  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
  assign rise_o  = filt_q & ~fprev_q;

  // Filtered level only moves after DEBOUNCE consecutive disagreeing samples.
  always_comb begin
    cnt_d  = '0;
    filt_d = filt_q;
    if (s2_q != filt_q) begin
      if (cnt_inc >= CNT_W'(DEBOUNCE)) filt_d = s2_q;
      else                             cnt_d  = cnt_inc;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      filt_q  <= 1'b0;
      fprev_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      s1_q    <= sensor_i;
      s2_q    <= s1_q;
      filt_q  <= filt_d;
      fprev_q <= filt_q;
      cnt_q   <= cnt_d;
    end
  end
endmodule

module special_request_conditioner #(
  parameter int         DEBOUNCE   = 4,
  parameter int         TIMEOUT    = 32,
  parameter int         COOLDOWN   = 16,
  parameter int         CNT_W      = 8,
  parameter logic [2:0] GREEN_CODE = 3'b001
) (
  input logic clk_i,
  input logic rst_i,
  special_request_conditioner_if.slave req_if
);
  localparam int NUM_ROADS = 2;  // index 0 = main, 1 = side

  typedef enum logic [1:0] {ST_IDLE, ST_GRANT_MAIN, ST_GRANT_SIDE, ST_COOL} state_t;

  logic [NUM_ROADS-1:0] sensor, rise, green;
  logic [NUM_ROADS-1:0] pend_q, special_q;
  logic [CNT_W-1:0]     tmr_q, tmr_inc;
  logic                 last_side_q, tp_q;
  logic                 gidx, served, tmr_hit, cool_hit;
  state_t               state_q;

  assign sensor = {req_if.Side_Sensor, req_if.Main_Sensor};
  assign green  = {req_if.Side_light == GREEN_CODE, req_if.Main_light == GREEN_CODE};

  generate
    for (genvar g = 0; g < NUM_ROADS; g++) begin : g_road
      src_lane #(.DEBOUNCE(DEBOUNCE), .CNT_W(CNT_W)) u_lane (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .sensor_i(sensor[g]),
        .rise_o  (rise[g])
      );
    end
  endgenerate

  assign tmr_inc  = (&tmr_q) ? tmr_q : tmr_q + 1'b1;
  assign gidx     = (state_q == ST_GRANT_SIDE);
  assign served   = green[gidx];
  assign tmr_hit  = tmr_inc >= CNT_W'(TIMEOUT);
  assign cool_hit = tmr_inc >= CNT_W'(COOLDOWN);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      tmr_q       <= '0;
      pend_q      <= '0;
      special_q   <= '0;
      last_side_q <= 1'b1;
      tp_q        <= 1'b0;
    end else begin
      tp_q   <= 1'b0;
      // A rise on the road being served is absorbed; the exit clear below wins.
      pend_q <= pend_q | rise;
      case (state_q)
        ST_IDLE: begin
          tmr_q <= '0;
          if (pend_q[0] && (!pend_q[1] || last_side_q)) begin
            state_q   <= ST_GRANT_MAIN;
            special_q <= 2'b01;
          end else if (pend_q[1]) begin
            state_q   <= ST_GRANT_SIDE;
            special_q <= 2'b10;
          end
        end
        ST_GRANT_MAIN, ST_GRANT_SIDE: begin
          tmr_q <= tmr_inc;
          if (served || tmr_hit) begin
            state_q      <= ST_COOL;
            tmr_q        <= '0;
            special_q    <= '0;
            pend_q[gidx] <= 1'b0;
            last_side_q  <= gidx;
            tp_q         <= ~served;
          end
        end
        ST_COOL: begin
          tmr_q <= tmr_inc;
          if (cool_hit) begin
            state_q <= ST_IDLE;
            tmr_q   <= '0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_if.Main_Special  = special_q[0];
  assign req_if.Side_Special  = special_q[1];
  assign req_if.Main_Pending  = pend_q[0];
  assign req_if.Side_Pending  = pend_q[1];
  assign req_if.Timeout_Pulse = tp_q;
endmodule

// File: tb/tb_special_request_conditioner.sv
// Randomised + directed bench; a behavioural model queues expected outputs
// each cycle and a negedge monitor compares them against the DUT.
module tb_special_request_conditioner;
  localparam int         DEBOUNCE = 4;
  localparam int         TIMEOUT  = 32;
  localparam int         COOLDOWN = 16;
  localparam logic [2:0] GREEN    = 3'b001;
  localparam logic [2:0] RED      = 3'b100;

  logic clk, rst;
  int   tests = 0, fails = 0;
  int   main_hold = 0, side_hold = 0;

  special_request_conditioner_if bus();

  special_request_conditioner #(
    .DEBOUNCE(DEBOUNCE), .TIMEOUT(TIMEOUT), .COOLDOWN(COOLDOWN),
    .CNT_W(8), .GREEN_CODE(GREEN)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .req_if(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [4:0] exp_q[$];
  bit [1:0] m_s1, m_s2, m_filt, m_fprev, m_pend, m_rise, m_sens;
  bit [1:0] m_green;
  int       m_run[2];
  int       m_phase, m_who, m_age, m_last;  // phase 0 idle, 1 granting, 2 cooldown
  bit       m_tp, m_ex;

  always @(posedge clk) begin
    if (rst) begin
      m_s1 = 0; m_s2 = 0; m_filt = 0; m_fprev = 0; m_pend = 0;
      m_run[0] = 0; m_run[1] = 0;
      m_phase = 0; m_who = 0; m_age = 0; m_last = 1; m_tp = 0;
    end else begin
      m_sens  = {bus.Side_Sensor, bus.Main_Sensor};
      m_green = {bus.Side_light == GREEN, bus.Main_light == GREEN};
      m_rise  = m_filt & ~m_fprev;
      m_fprev = m_filt;
      for (int r = 0; r < 2; r++) begin
        if (m_s2[r] != m_filt[r]) begin
          m_run[r]++;
          if (m_run[r] >= DEBOUNCE) begin m_filt[r] = ~m_filt[r]; m_run[r] = 0; end
        end else m_run[r] = 0;
      end
      m_s2 = m_s1;
      m_s1 = m_sens;
      m_ex = 0;
      m_tp = 0;
      case (m_phase)
        0: begin
          if (m_pend[0] && (!m_pend[1] || m_last == 1)) begin m_phase = 1; m_who = 0; m_age = 0; end
          else if (m_pend[1]) begin m_phase = 1; m_who = 1; m_age = 0; end
        end
        1: begin
          m_age++;
          if (m_green[m_who] || m_age >= TIMEOUT) begin
            m_ex = 1; m_tp = !m_green[m_who]; m_last = m_who; m_phase = 2; m_age = 0;
          end
        end
        default: begin
          m_age++;
          if (m_age >= COOLDOWN) m_phase = 0;
        end
      endcase
      for (int r = 0; r < 2; r++) begin
        if (m_ex && m_who == r) m_pend[r] = 0;
        else if (m_rise[r])     m_pend[r] = 1;
      end
    end
    exp_q.push_back({m_tp, m_pend[1], m_pend[0], (m_phase == 1 && m_who == 1), (m_phase == 1 && m_who == 0)});
  end

  // ---------------- monitor ----------------
  logic [4:0] mon_e, mon_a;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_a = {bus.Timeout_Pulse, bus.Side_Pending, bus.Main_Pending, bus.Side_Special, bus.Main_Special};
      tests++;
      if (mon_a !== mon_e) begin
        fails++;
        $display("FAIL scoreboard @%0t: dut=%b model=%b (tp,sp,mp,ss,ms)", $time, mon_a, mon_e);
      end
      tests++;
      if (mon_a[0] && mon_a[1]) begin
        fails++;
        $display("FAIL mutex @%0t: both Special outputs high, expected at most one", $time);
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input int act, input int expv);
    tests++;
    if (act != expv) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
    bus.Main_Sensor = (main_hold > 0);
    bus.Side_Sensor = (side_hold > 0);
    if (main_hold > 0) main_hold--;
    if (side_hold > 0) side_hold--;
  endtask

  function automatic int outs();
    return int'({bus.Timeout_Pulse, bus.Side_Pending, bus.Main_Pending, bus.Side_Special, bus.Main_Special});
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    main_hold = 0; side_hold = 0;
    bus.Main_light = RED; bus.Side_light = RED;
    tick();
    chk("reset_outputs", outs(), 0);
    tick();
    rst = 1'b0;
  endtask

  // Ticks until the chosen Special output is seen high; n = ticks taken, -1 on expiry.
  task automatic wait_sig(input int which, input int maxc, output int n);
    n = -1;
    for (int i = 1; i <= maxc; i++) begin
      tick();
      if ((which == 0 ? bus.Main_Special : bus.Side_Special) === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  // ---------------- stimulus ----------------
  int  n, hi, tpc, acc, mrun, srun;
  bit  mlvl, slvl;

  initial begin
    rst = 1'b1;
    bus.Main_Sensor = 1'b0; bus.Side_Sensor = 1'b0;
    bus.Main_light = RED;   bus.Side_light = RED;

    // 1: main request served by green five cycles into the grant
    do_reset();
    main_hold = 10;
    tick();
    wait_sig(0, 40, n);
    chk("t1_latency", n, DEBOUNCE + 4);
    chk("t1_pending_during_grant", int'(bus.Main_Pending), 1);
    hi = 1;
    repeat (4) begin tick(); hi += int'(bus.Main_Special); end
    bus.Main_light = GREEN;
    tick();
    chk("t1_special_drop", int'(bus.Main_Special), 0);
    chk("t1_pending_clear", int'(bus.Main_Pending), 0);
    tpc = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (i == 3) bus.Main_light = RED;
      hi  += int'(bus.Main_Special);
      tpc += int'(bus.Timeout_Pulse);
    end
    chk("t1_high_cycles", hi, 5);
    chk("t1_no_timeout", tpc, 0);

    // 2: side glitch shorter than the debounce window
    side_hold = 3;
    acc = 0;
    repeat (30) begin tick(); acc += int'(bus.Side_Pending | bus.Side_Special); end
    chk("t2_glitch_ignored", acc, 0);

    // 3: simultaneous requests after reset, main first, side after cooldown
    do_reset();
    main_hold = 10; side_hold = 10;
    tick();
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (bus.Main_Special || bus.Side_Special) begin n = i; break; end
    end
    chk("t3_first_latency", n, DEBOUNCE + 4);
    chk("t3_main_first", int'(bus.Main_Special), 1);
    chk("t3_side_pending", int'(bus.Side_Pending), 1);
    bus.Main_light = GREEN;
    wait_sig(1, 60, n);
    chk("t3_side_after_cooldown", n, COOLDOWN + 2);
    bus.Main_light = RED;
    bus.Side_light = GREEN;
    tick();
    bus.Side_light = RED;
    chk("t3_side_served", int'(bus.Side_Special), 0);

    // 4: side request never sees green -> timeout
    do_reset();
    side_hold = 10;
    tick();
    wait_sig(1, 40, n);
    hi = 1; tpc = 0;
    repeat (60) begin
      tick();
      hi  += int'(bus.Side_Special);
      tpc += int'(bus.Timeout_Pulse);
    end
    chk("t4_high_cycles", hi, TIMEOUT);
    chk("t4_timeout_pulses", tpc, 1);
    chk("t4_pending_clear", int'(bus.Side_Pending), 0);

    // 5: reset mid-grant clears immediately, then re-request from scratch
    do_reset();
    main_hold = 1000;
    tick();
    wait_sig(0, 40, n);
    repeat (3) tick();
    chk("t5_pre_reset_grant", int'(bus.Main_Special), 1);
    rst = 1'b1;
    #1;
    chk("t5_async_reset", outs(), 0);
    tick();
    tick();
    rst = 1'b0;
    wait_sig(0, 40, n);
    chk("t5_regrant_latency", n, DEBOUNCE + 4);
    main_hold = 0;
    bus.Main_light = GREEN;
    tick();
    bus.Main_light = RED;
    repeat (40) tick();

    // 6: second main edge during the grant is merged
    do_reset();
    main_hold = 10;
    tick();
    wait_sig(0, 40, n);
    repeat (8) tick();
    main_hold = 10;
    repeat (12) tick();
    chk("t6_still_granted", int'(bus.Main_Special), 1);
    bus.Main_light = GREEN;
    tick();
    bus.Main_light = RED;
    chk("t6_served", int'(bus.Main_Special), 0);
    chk("t6_pending_clear", int'(bus.Main_Pending), 0);
    acc = 0;
    repeat (50) begin tick(); acc += int'(bus.Main_Special | bus.Main_Pending); end
    chk("t6_no_regrant", acc, 0);

    // random traffic, occasional reset pulses
    do_reset();
    mrun = 0; srun = 0;
    for (int i = 0; i < 2500; i++) begin
      tick();
      if (mrun == 0) begin mlvl = ($urandom_range(0, 9) < 4); mrun = $urandom_range(1, 15); end
      if (srun == 0) begin slvl = ($urandom_range(0, 9) < 4); srun = $urandom_range(1, 15); end
      mrun--; srun--;
      bus.Main_Sensor = mlvl;
      bus.Side_Sensor = slvl;
      bus.Main_light  = ($urandom_range(0, 15) == 0) ? GREEN : (($urandom_range(0, 1) == 0) ? RED : 3'b010);
      bus.Side_light  = ($urandom_range(0, 15) == 0) ? GREEN : (($urandom_range(0, 1) == 0) ? RED : 3'b010);
      rst = ($urandom_range(0, 599) == 0);
    end
    rst = 1'b0;
    repeat (4) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    fails++;
    $display("FAIL watchdog: run did not complete within time limit");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
